// File: rtl/sprite_rom_read_arbiter_if.sv
// Bus between the sprite renderers, the shared ROM read port and the arbiter.
// master = renderers plus ROM data side, slave = arbiter.
interface sprite_rom_read_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned AW    = 11,
   parameter int unsigned DW    = 4
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ*AW-1:0] addr;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    rvalid;
   logic [DW-1:0]       rdata;
   logic                oob_err;
   logic [AW-1:0]       rom_raddr;
   logic [DW-1:0]       rom_rdata;

   modport master (
      output req, addr, rom_rdata,
      input  gnt, rvalid, rdata, oob_err, rom_raddr
   );

   modport slave (
      input  req, addr, rom_rdata,
      output gnt, rvalid, rdata, oob_err, rom_raddr
   );
endinterface

// File: rtl/sprite_rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among N_REQ renderers.
// Define SPRITE_ARB_FIXED_PRIO_EN to give requester 0 absolute priority over the rest.
module sprite_rom_read_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned AW    = 11,
   parameter int unsigned DW    = 4,
   parameter int unsigned DEPTH = 1536
) (
   input logic                      Clk,
   input logic                      Reset_n,
   sprite_rom_read_arbiter_if.slave bus
);
   localparam int unsigned PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int          NR      = int'(N_REQ);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
   localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
   localparam logic [PW-1:0] PTR_RST = '0;
`endif

   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    winner;
   logic             any_gnt;
   logic [N_REQ-1:0] gnt_c;
   logic [AW-1:0]    win_addr;
   logic             oob_c;
   logic [N_REQ-1:0] rvalid_q;
   logic             oob_q;
   int               idx;
   int               base;

   always_comb begin
      any_gnt = 1'b0;
      winner  = '0;
      idx     = 0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      if (bus.req[0]) begin
         any_gnt = 1'b1;
      end else begin
         // Requesters 1..N_REQ-1 rotate among themselves starting at rr_ptr
         for (int k = 0; k < NR - 1; k++) begin
            idx = 1 + ((int'(rr_ptr) - 1 + k) % (NR - 1));
            if (!any_gnt && bus.req[idx]) begin
               any_gnt = 1'b1;
               winner  = PW'(idx);
            end
         end
      end
`else
      for (int k = 0; k < NR; k++) begin
         idx = (int'(rr_ptr) + k) % NR;
         if (!any_gnt && bus.req[idx]) begin
            any_gnt = 1'b1;
            winner  = PW'(idx);
         end
      end
`endif
   end

   always_comb begin
      gnt_c = '0;
      if (any_gnt) gnt_c[winner] = 1'b1;
      base     = int'(winner) * int'(AW);
      win_addr = bus.addr[base +: AW];
      oob_c    = any_gnt && (32'(win_addr) >= DEPTH_W);
   end

   assign bus.gnt       = gnt_c;
   assign bus.rom_raddr = (any_gnt && !oob_c) ? win_addr : '0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rvalid_q <= '0;
         oob_q    <= 1'b0;
         rr_ptr   <= PTR_RST;
      end else begin
         rvalid_q <= gnt_c;
         oob_q    <= oob_c;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
         if (any_gnt && winner != '0) begin
            rr_ptr <= (int'(winner) == NR - 1) ? PW'(1) : winner + PW'(1);
         end
`else
         if (any_gnt) rr_ptr <= PW'((int'(winner) + 1) % NR);
`endif
      end
   end

   // ROM data arrives in the return cycle, so only the mask is registered here
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = oob_q ? {DW{1'b0}} : bus.rom_rdata;
   assign bus.oob_err = oob_q & (|rvalid_q);
endmodule

// File: tb/tb_sprite_rom_read_arbiter.sv
// Self-checking bench for sprite_rom_read_arbiter with a behavioural ROM and arbiter model.
module tb_sprite_rom_read_arbiter;
   localparam int N     = 4;
   localparam int AW    = 11;
   localparam int DW    = 4;
   localparam int DEPTH = 1536;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
   localparam int PTR0 = 1;
`else
   localparam int PTR0 = 0;
`endif

   logic Clk;
   logic Reset_n;
   logic [DW-1:0] mem [0:2047];

   sprite_rom_read_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

   sprite_rom_read_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROM with 1-cycle registered read
   always @(posedge Clk) bus.rom_rdata <= mem[bus.rom_raddr];

   int n_tests = 0;
   int n_fail  = 0;

   int            ptr;
   logic [N-1:0]  exp_rvalid;
   logic          exp_oob;
   logic [DW-1:0] exp_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Winner by priority order: who comes first when listed from the pointer onward
   function automatic int pick(input logic [N-1:0] r, input int p);
      int order [$];
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      order.push_back(0);
      for (int k = 0; k < N - 1; k++) order.push_back(1 + (p - 1 + k) % (N - 1));
`else
      for (int k = 0; k < N; k++) order.push_back((p + k) % N);
`endif
      foreach (order[j]) if (r[order[j]]) return order[j];
      return -1;
   endfunction

   function automatic int next_ptr(input int w, input int p);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      if (w <= 0) return p;
      return (w == N - 1) ? 1 : w + 1;
`else
      if (w < 0) return p;
      return (w + 1) % N;
`endif
   endfunction

   task automatic set_reset(input logic v);
      Reset_n = v;
      if (!v) begin
         exp_rvalid = '0;
         exp_oob    = 1'b0;
         ptr        = PTR0;
      end
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1
   task automatic cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a, output logic [N-1:0] g);
      int w;
      logic [N-1:0]  eg;
      logic [AW-1:0] wa;
      logic [AW-1:0] ea;
      bus.req  = r;
      bus.addr = a;
      @(negedge Clk);
      check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
      check("oob_err", 32'(bus.oob_err), 32'(exp_oob));
      if (exp_rvalid != '0) check("rdata", 32'(bus.rdata), 32'(exp_rdata));
      g = '0;
      if (Reset_n) begin
         w  = pick(r, ptr);
         eg = (w < 0) ? '0 : N'(1 << w);
         wa = (w < 0) ? '0 : a[w*AW +: AW];
         ea = (w >= 0 && int'(wa) < DEPTH) ? wa : '0;
         check("gnt", 32'(bus.gnt), 32'(eg));
         check("rom_raddr", 32'(bus.rom_raddr), 32'(ea));
         g          = bus.gnt;
         exp_rvalid = eg;
         exp_oob    = (w >= 0) && (int'(wa) >= DEPTH);
         exp_rdata  = exp_oob ? '0 : mem[wa];
         ptr        = next_ptr(w, ptr);
      end
      @(posedge Clk);
      #1;
   endtask

   logic [N-1:0]    g;
   logic [N-1:0]    pend;
   logic [N*AW-1:0] paddr;
   logic [AW-1:0]   ra;

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
      bus.req  = '0;
      bus.addr = '0;
      set_reset(1'b0);
      repeat (2) @(posedge Clk);
      #1;
      // Reset state while Reset_n held low
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_oob_err", 32'(bus.oob_err), 32'd0);
      set_reset(1'b1);

      // Idle: no grants, address forced to 0
      repeat (5) cycle('0, '0, g);

      // Single read from requester 0 at address 100
      paddr = '0;
      paddr[0 +: AW] = 11'd100;
      cycle(4'b0001, paddr, g);
      check("t2_gnt", 32'(g), 32'h1);
      cycle('0, '0, g);

      // All requesting from a fresh reset
      set_reset(1'b0);
      cycle('0, '0, g);
      set_reset(1'b1);
      for (int i = 0; i < N; i++) paddr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      repeat (8) cycle(4'b1111, paddr, g);
      cycle('0, '0, g);

      // Out-of-bounds address on requester 2
      paddr = '0;
      paddr[2*AW +: AW] = 11'd1536;
      cycle(4'b0100, paddr, g);
      cycle('0, '0, g);
      check("t4_oob_seen", 32'(exp_oob), 32'd0);

      // Reset pulsed mid-stream
      for (int i = 0; i < N; i++) paddr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      cycle(4'b1111, paddr, g);
      cycle(4'b1111, paddr, g);
      set_reset(1'b0);
      cycle(4'b1111, paddr, g);
      set_reset(1'b1);
      cycle(4'b1111, paddr, g);
      check("t5_first_gnt", 32'(g), 32'h1);
      repeat (5) cycle(4'b1111, paddr, g);
      // Requester 0 drops out; the others keep rotating
      repeat (6) cycle(4'b1110, paddr, g);

      // Randomised traffic with hold-until-granted handshake
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 55) begin
               pend[i] = 1'b1;
               ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 2047))
                                                : AW'($urandom_range(0, DEPTH - 1));
               paddr[i*AW +: AW] = ra;
            end
         end
         if (c == 200) set_reset(1'b0);
         if (c == 202) set_reset(1'b1);
         cycle(pend, paddr, g);
         pend = pend & ~g;
      end
      cycle('0, '0, g);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
